// File: rtl/f9pcap_pkg.sv
// Shared types and helpers for the f9pcap transmit scheduler.
// Holds the scheduler state encoding and the round-robin pick function.
package f9pcap_pkg;

  localparam int IDX_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

  // Index of the first set bit of valid at or after ptr, wrapping modulo n.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [15:0] valid,
                                                   input logic [IDX_WIDTH-1:0] ptr,
                                                   input int n);
    logic [IDX_WIDTH-1:0] pick;
    logic found;
    int j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!found && valid[j[3:0]]) begin
          pick  = IDX_WIDTH'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational source pick (optional strict-priority source, else round-robin)
// plus the round-robin pointer, advanced past the source whose frame just ended.
module rr_priority_arbiter
  import f9pcap_pkg::*;
#(
  parameter int N_COUNT  = 3,
  parameter int PRIO_IDX = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_COUNT-1:0]   valid,
  input  logic                 advance,
  input  logic [IDX_WIDTH-1:0] grant,
  output logic [IDX_WIDTH-1:0] pick
);

  localparam bit PRIO_EN   = (PRIO_IDX >= 0);
  localparam int PRIO_SAFE = PRIO_EN ? PRIO_IDX : 0;

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [15:0]          valid_ext;

  assign valid_ext = 16'(valid);

  always_comb begin
    pick = rr_pick(valid_ext, rr_ptr, N_COUNT);
    if (PRIO_EN && valid_ext[PRIO_SAFE]) pick = IDX_WIDTH'(PRIO_SAFE);
  end

  // The pointer moves past the finishing source even when it was the priority one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant >= IDX_WIDTH'(N_COUNT - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/f9pcap_tx_scheduler.sv
// Frame-level scheduler sharing one TEMAC transmit stream between N sources,
// with link gating, programmable inter-frame gap and runaway-frame truncation.
module f9pcap_tx_scheduler
  import f9pcap_pkg::*;
#(
  parameter int N_COUNT         = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int PRIO_IDX        = 2,
  parameter int GAP_WIDTH       = 16,
  parameter int MAX_FRAME_BYTES = 1600,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [N_COUNT-1:0]              n_valid_in,
  output logic [N_COUNT-1:0]              n_ready_out,
  input  logic [N_COUNT*DATA_WIDTH-1:0]   n_data_in,
  input  logic [N_COUNT-1:0]              n_last_in,
  output logic                            o_valid_out,
  input  logic                            o_ready_in,
  output logic [DATA_WIDTH-1:0]           o_data_out,
  output logic                            o_last_out,
  input  logic                            link_ready_in,
  input  logic [GAP_WIDTH-1:0]            gap_cfg_in,
  output logic [3:0]                      grant_idx_out,
  output logic                            busy_out,
  output logic [CNT_WIDTH-1:0]            frames_sent_out,
  output logic [CNT_WIDTH-1:0]            frames_trunc_out
);

  localparam int BEAT_WIDTH = $clog2(MAX_FRAME_BYTES + 1);

  state_t                  state, state_nxt;
  logic [IDX_WIDTH-1:0]    grant_idx;
  logic [IDX_WIDTH-1:0]    pick;
  logic [BEAT_WIDTH-1:0]   beat_cnt;
  logic [GAP_WIDTH-1:0]    gap_cnt;
  logic [CNT_WIDTH-1:0]    frames_sent;
  logic [CNT_WIDTH-1:0]    frames_trunc;
  logic [N_COUNT-1:0]      grant_oh;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    force_last;
  logic                    frame_end;

  rr_priority_arbiter #(
    .N_COUNT  (N_COUNT),
    .PRIO_IDX (PRIO_IDX)
  ) u_arbiter (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .valid   (n_valid_in),
    .advance (frame_end),
    .grant   (grant_idx),
    .pick    (pick)
  );

  always_comb begin
    grant_oh = '0;
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    for (int i = 0; i < N_COUNT; i++) begin
      if (grant_idx == IDX_WIDTH'(i)) begin
        grant_oh[i] = 1'b1;
        g_valid     = n_valid_in[i];
        g_last      = n_last_in[i];
        g_data      = n_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign force_last = (beat_cnt == BEAT_WIDTH'(MAX_FRAME_BYTES - 1));
  assign frame_end  = (state == XFER) && o_valid_out && o_ready_in && o_last_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // o_valid_out depends only on the registered grant and source valid, never on o_ready_in.
  always_comb begin
    state_nxt   = state;
    n_ready_out = '0;
    o_valid_out = 1'b0;
    o_data_out  = '0;
    o_last_out  = 1'b0;
    case (state)
      IDLE: begin
        if (link_ready_in && (|n_valid_in)) state_nxt = XFER;
      end
      XFER: begin
        o_valid_out = g_valid;
        o_data_out  = g_data;
        o_last_out  = g_last | force_last;
        n_ready_out = grant_oh & {N_COUNT{o_ready_in}};
        if (o_valid_out && o_ready_in && o_last_out) begin
          if (!g_last)               state_nxt = DROP;
          else if (gap_cfg_in == '0) state_nxt = IDLE;
          else                       state_nxt = GAP;
        end
      end
      DROP: begin
        n_ready_out = grant_oh;
        if (g_valid && g_last) state_nxt = (gap_cnt == '0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= GAP_WIDTH'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gap is sampled at frame end and held through DROP, so later cfg changes cannot stretch it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_idx    <= '0;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      frames_sent  <= '0;
      frames_trunc <= '0;
    end else begin
      if (state == IDLE && state_nxt == XFER) begin
        grant_idx <= pick;
        beat_cnt  <= '0;
      end
      if (state == XFER && o_valid_out && o_ready_in) begin
        beat_cnt <= frame_end ? '0 : beat_cnt + BEAT_WIDTH'(1);
      end
      if (frame_end) begin
        gap_cnt <= gap_cfg_in;
        if (frames_sent != '1) frames_sent <= frames_sent + 1'b1;
        if (!g_last && frames_trunc != '1) frames_trunc <= frames_trunc + 1'b1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign grant_idx_out    = grant_idx;
  assign busy_out         = (state != IDLE);
  assign frames_sent_out  = frames_sent;
  assign frames_trunc_out = frames_trunc;

endmodule

// File: tb/tb_f9pcap_tx_scheduler.sv
// Scoreboard bench for f9pcap_tx_scheduler: source models feed frames, expected
// output beats are queued at stimulus time and a monitor checks each handshake.
module tb_f9pcap_tx_scheduler;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int GW   = 16;
  localparam int MAXB = 100;
  localparam int CW   = 32;
  localparam int MEMD = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    n_valid_in = '0;
  logic [N-1:0]    n_ready_out;
  logic [N*DW-1:0] n_data_in = '0;
  logic [N-1:0]    n_last_in = '0;
  logic            o_valid_out;
  logic            o_ready_in = 1'b1;
  logic [DW-1:0]   o_data_out;
  logic            o_last_out;
  logic            link_ready_in = 1'b1;
  logic [GW-1:0]   gap_cfg_in = '0;
  logic [3:0]      grant_idx_out;
  logic            busy_out;
  logic [CW-1:0]   frames_sent_out;
  logic [CW-1:0]   frames_trunc_out;

  always #5 clk = ~clk;

  f9pcap_tx_scheduler #(
    .N_COUNT(N), .DATA_WIDTH(DW), .PRIO_IDX(2), .GAP_WIDTH(GW),
    .MAX_FRAME_BYTES(MAXB), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .n_valid_in(n_valid_in), .n_ready_out(n_ready_out),
    .n_data_in(n_data_in), .n_last_in(n_last_in),
    .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
    .o_data_out(o_data_out), .o_last_out(o_last_out),
    .link_ready_in(link_ready_in), .gap_cfg_in(gap_cfg_in),
    .grant_idx_out(grant_idx_out), .busy_out(busy_out),
    .frames_sent_out(frames_sent_out), .frames_trunc_out(frames_trunc_out)
  );

  typedef struct packed {
    logic [3:0] src;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         gap_meas[$];
  logic [8:0] src_mem [N][MEMD];
  int         src_wr [N];
  int         src_rd [N];
  int         checks = 0;
  int         failures = 0;
  bit         rand_ready = 1'b0;
  int         beat_no = 0;
  int         frames_seen = 0;
  int         idle_run = 0;
  bit         in_frame = 1'b0;
  bit         have_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Queue a frame in a source model and the beats the output should show for it.
  task automatic applyStimulus(input int src, input int len, input int seed);
    logic [7:0] d;
    logic       l;
    exp_t       e;
    for (int k = 0; k < len; k++) begin
      d = 8'((src * 64) + (seed * 13) + k);
      l = (k == len - 1);
      src_mem[src][src_wr[src] % MEMD] = {l, d};
      src_wr[src]++;
      if (k < MAXB) begin
        e.src  = 4'(src);
        e.data = d;
        e.last = l || (k == MAXB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        {n_last_in[i], n_data_in[i*DW +: DW]} = src_mem[i][src_rd[i] % MEMD];
        n_valid_in[i] = 1'b1;
      end else begin
        n_valid_in[i]          = 1'b0;
        n_last_in[i]           = 1'b0;
        n_data_in[i*DW +: DW]  = '0;
      end
    end
  endtask

  initial begin
    bit take [N];
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) take[i] = n_valid_in[i] && n_ready_out[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (take[i]) src_rd[i]++;
      o_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_sources();
    end
  end

  // Monitor: every output handshake pops one expected beat; also measures idle gaps.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        have_prev = 1'b0;
        beat_no   = 0;
        idle_run  = 0;
      end else if (o_valid_out && o_ready_in) begin
        if (!in_frame && have_prev) gap_meas.push_back(idle_run);
        in_frame = 1'b1;
        beat_no++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", 32'(o_data_out), 32'(e.data));
          checkOutput("out_last", 32'(o_last_out), 32'(e.last));
          checkOutput("out_grant", 32'(grant_idx_out), 32'(e.src));
        end
        if (o_last_out) begin
          in_frame  = 1'b0;
          have_prev = 1'b1;
          idle_run  = 0;
          beat_no   = 0;
          frames_seen++;
        end
      end else if (!in_frame && !o_valid_out) begin
        idle_run++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    gap_meas.delete();
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_out && src_rd[0] == src_wr[0] &&
          src_rd[1] == src_wr[1] && src_rd[2] == src_wr[2]) done = 1'b1;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic wait_beat(input int n, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      if (beat_no >= n) done = 1'b1;
    end
    checkOutput($sformatf("reach_beat_%0d", n), 32'(done), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      if (frames_seen >= target) done = 1'b1;
    end
    checkOutput("reach_frame_end", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_n_ready", 32'(n_ready_out), 32'd0);
    checkOutput("rst_o_valid", 32'(o_valid_out), 32'd0);
    checkOutput("rst_o_last", 32'(o_last_out), 32'd0);
    checkOutput("rst_o_data", 32'(o_data_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_grant", 32'(grant_idx_out), 32'd0);
    checkOutput("rst_sent", frames_sent_out, 32'd0);
    checkOutput("rst_trunc", frames_trunc_out, 32'd0);
  endtask

  initial begin
    int base;
    int vcount;
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    #2 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] round-robin between sources 0 and 1, gap 0");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(0, 64, f);
      applyStimulus(1, 64, f + 10);
    end
    wait_drain(2000, "rr_drained");
    checkOutput("rr_frames_sent", frames_sent_out, 32'd6);
    checkOutput("rr_gap_count", 32'(gap_meas.size()), 32'd5);
    foreach (gap_meas[k]) checkOutput($sformatf("rr_gap_%0d", k), 32'(gap_meas[k]), 32'd1);

    $display("[TB] strict priority for source 2");
    do_reset();
    applyStimulus(2, 16, 1);
    applyStimulus(2, 16, 2);
    applyStimulus(0, 16, 3);
    applyStimulus(0, 16, 4);
    applyStimulus(0, 16, 5);
    wait_drain(1000, "prio_drained");
    checkOutput("prio_frames_sent", frames_sent_out, 32'd5);
    applyStimulus(0, 64, 6);
    wait_beat(10, 500);
    applyStimulus(2, 16, 7);
    wait_drain(1000, "prio_nopreempt_drained");
    checkOutput("prio_frames_sent2", frames_sent_out, 32'd7);

    $display("[TB] inter-frame gap 12, changed mid-gap to 3");
    do_reset();
    gap_cfg_in = 16'd12;
    base = frames_seen;
    applyStimulus(0, 20, 1);
    applyStimulus(0, 20, 2);
    applyStimulus(0, 20, 3);
    wait_frames(base + 1, 500);
    repeat (3) @(posedge clk);
    gap_cfg_in = 16'd3;
    wait_drain(1000, "gap_drained");
    checkOutput("gap_count", 32'(gap_meas.size()), 32'd2);
    if (gap_meas.size() == 2) begin
      checkOutput("gap_first", 32'(gap_meas[0]), 32'd13);
      checkOutput("gap_second", 32'(gap_meas[1]), 32'd4);
    end
    gap_cfg_in = '0;

    $display("[TB] runaway frame truncation");
    do_reset();
    applyStimulus(0, 150, 4);
    applyStimulus(1, 10, 5);
    wait_drain(1000, "trunc_drained");
    checkOutput("trunc_count", frames_trunc_out, 32'd1);
    checkOutput("trunc_sent", frames_sent_out, 32'd2);
    checkOutput("trunc_consumed", 32'(src_rd[0]), 32'(src_wr[0]));

    $display("[TB] link loss mid-frame");
    do_reset();
    base = frames_seen;
    applyStimulus(0, 64, 6);
    wait_beat(20, 500);
    #1 link_ready_in = 1'b0;
    wait_frames(base + 1, 500);
    applyStimulus(1, 32, 7);
    base = src_rd[1];
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid_out) vcount++;
    end
    checkOutput("link_down_valid_cycles", 32'(vcount), 32'd0);
    checkOutput("link_down_busy", 32'(busy_out), 32'd0);
    checkOutput("link_down_consumed", 32'(src_rd[1]), 32'(base));
    link_ready_in = 1'b1;
    wait_drain(1000, "link_drained");
    checkOutput("link_frames_sent", frames_sent_out, 32'd2);

    $display("[TB] random ready with reset mid-frame");
    rand_ready = 1'b1;
    applyStimulus(1, 64, 8);
    wait_beat(30, 1000);
    #2 rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 40, 9);
    wait_drain(2000, "rand_drained");
    checkOutput("rand_frames_sent", frames_sent_out, 32'd1);
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/f9pcap_tx_scheduler.md
Name: f9pcap_tx_scheduler

Overview:
Frame-level scheduler that shares one 8-bit TEMAC transmit stream between N AXI-Stream sources: per-SFP f9pcap capture streams plus the device-status stream. Grants whole frames using fixed priority for one source and round-robin for the rest, and enforces a programmable inter-frame gap. Gates new grants on link state and truncates runaway frames. Sits in the temac_tx clock domain, one instance per PHY, between the per-source CDC buffers and the TEMAC.

Parameters:
N_COUNT, 3, number of requesting sources (2..16)
DATA_WIDTH, 8, stream data width
PRIO_IDX, 2, index of the strict-priority source; -1 = pure round-robin
GAP_WIDTH, 16, width of gap_cfg_in
MAX_FRAME_BYTES, 1600, beats after which a frame is force-terminated
CNT_WIDTH, 32, statistics counter width

Ports:
clk_in  in  1  TEMAC tx clock
rst_n_in  in  1  reset, asynchronous, active-low
n_valid_in  in  N_COUNT  per-source valid
n_ready_out  out  N_COUNT  per-source ready
n_data_in  in  N_COUNT*DATA_WIDTH  per-source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
n_last_in  in  N_COUNT  per-source last
o_valid_out  out  1  TEMAC valid
o_ready_in  in  1  TEMAC ready
o_data_out  out  DATA_WIDTH  TEMAC data
o_last_out  out  1  TEMAC last
link_ready_in  in  1  PHY link up
gap_cfg_in  in  GAP_WIDTH  idle cycles required after each frame
grant_idx_out  out  4  index of the current or last granted source
busy_out  out  1  high in XFER, DROP or GAP
frames_sent_out  out  CNT_WIDTH  frames completed on the output, saturating
frames_trunc_out  out  CNT_WIDTH  frames force-terminated, saturating

Behaviour:
- Reset: state=IDLE; rr_ptr=0; grant_idx=0; all counters 0. During reset n_ready_out=0, o_valid_out=0, o_last_out=0, o_data_out=0, busy_out=0.
- States:
  - IDLE: arbitration.
  - XFER: grant is locked to one source.
  - DROP: discards the rest of a truncated frame.
  - GAP: counts out the inter-frame gap.
- IDLE:
  - Arbitrate only when link_ready_in=1 and any n_valid_in is set.
  - If PRIO_IDX>=0 and n_valid_in[PRIO_IDX]=1, grant PRIO_IDX.
  - Otherwise grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_COUNT.
  - Register grant_idx; next cycle is XFER. Arbitration latency is 1 cycle; outputs are deasserted in IDLE.
- XFER:
  - o_valid_out = n_valid_in[g]; o_data_out = n_data_in[g] (combinational mux on the registered grant).
  - n_ready_out[g] = o_ready_in; all other ready bits are 0.
  - Beat counter increments on each output handshake.
  - o_last_out = n_last_in[g] OR (beat count == MAX_FRAME_BYTES-1).
- Frame end: on a handshake with o_last_out=1:
  - frames_sent increments.
  - rr_ptr = g+1 modulo N_COUNT; this applies even when g=PRIO_IDX.
  - gap_cfg_in is sampled into the gap counter.
  - If n_last_in[g]=0 (forced last): frames_trunc increments and the next state is DROP.
  - Otherwise the next state is GAP, or IDLE directly if the sampled gap is 0.
- DROP: n_ready_out[g]=1; o_valid_out=0; data is discarded until a handshake with n_last_in[g]=1, then go to GAP (or IDLE if gap is 0).
- GAP: decrement the counter every cycle; go to IDLE when it reaches 1. Exactly gap_cfg_in cycles with o_valid_out=0.
- Link loss:
  - IDLE/GAP: no new grant is issued.
  - XFER: the frame in progress completes; frames are never truncated for link loss.
- Source behaviour:
  - A granted source deasserting valid mid-frame leaves a bubble; the grant stays held.
  - Grants are never pre-empted mid-frame, including by the priority source.
- gap_cfg_in changing mid-gap has no effect on the gap in progress.
- Counters hold at all-ones.
- Reset asserted mid-frame returns to IDLE immediately. The partial frame is not counted; downstream sees a truncated frame without last, which is acceptable because the TEMAC shares this reset.
- No combinational path from o_ready_in to o_valid_out.

Decomposition:
- Shared package f9pcap_pkg:
  - typedef state_t {IDLE, XFER, DROP, GAP};
  - IDX_WIDTH = 4;
  - function rr_pick(valid, ptr) returning the index of the first set bit at or after ptr.
- One natural sub-module: rr_priority_arbiter (combinational pick plus rr_ptr register). Gap countdown stays inline.

Test Plan:
1. N=3, PRIO_IDX=-1, all sources continuously offer 64-byte frames, gap=0 -> grants 0,1,2,0,1,2; one idle cycle between frames; frames_sent=6 after 6 frames.
2. PRIO_IDX=2, sources 0 and 2 always valid -> source 2 granted every arbitration; a source-2 request raised mid-frame of source 0 waits for source 0's last.
3. gap_cfg_in=12, single source, back-to-back frames -> exactly 12 cycles of o_valid_out=0 after each last handshake plus 1 arbitration cycle.
4. MAX_FRAME_BYTES=100, source sends 150 bytes -> output shows 100 beats with last on beat 100; 50 input beats consumed with no output; frames_trunc=1, frames_sent=1.
5. link_ready_in drops at beat 20 of a 64-byte frame -> all 64 beats are sent; no new grant until link_ready_in=1 again.
6. o_ready_in toggling randomly, rst_n_in asserted at beat 30 -> data integrity holds; immediately after reset all ready/valid are 0, state is IDLE and counters are 0.
